// File: rtl/alu_seq_pkg.sv
// Shared widths, FSM state encoding and ALU control codes for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 1 << REG_AW;
  localparam int CNT_W   = 4;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WB
  } seq_state_e;

  function automatic logic is_x0(input logic [REG_AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operation request, ALU operand/result and completion signals of the ALU operand sequencer.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [REG_AW-1:0] op_rs1;
  logic [REG_AW-1:0] op_rs2;
  logic [REG_AW-1:0] op_rd;
  logic              op_imm_sel;
  logic [XLEN-1:0]   op_imm;
  logic              op_ctrl;
  logic [XLEN-1:0]   data_r1;
  logic [XLEN-1:0]   data_r2;
  logic              ALUControl;
  logic [XLEN-1:0]   ALUResult;
  logic              Negative;
  logic              done;
  logic [XLEN-1:0]   result;
  logic              result_neg;
  logic              busy;

  // Master issues operations and hosts the ALU; slave is the sequencer.
  modport master (
    output op_valid, op_rs1, op_rs2, op_rd, op_imm_sel, op_imm, op_ctrl,
    output ALUResult, Negative,
    input  op_ready, data_r1, data_r2, ALUControl, done, result, result_neg, busy
  );

  modport slave (
    input  op_valid, op_rs1, op_rs2, op_rd, op_imm_sel, op_imm, op_ctrl,
    input  ALUResult, Negative,
    output op_ready, data_r1, data_r2, ALUControl, done, result, result_neg, busy
  );

endinterface

// File: rtl/rv_regfile.sv
// 32 x XLEN register file: two combinational reads, one synchronous write, x0 hardwired to zero.
// A third debug read port is added when ALU_SEQ_DBG_EN is defined.
module rv_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o,
`ifdef ALU_SEQ_DBG_EN
  input  logic [REG_AW-1:0] ra3_i,
  output logic [XLEN-1:0]   rd3_o,
`endif
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  logic [XLEN-1:0] regs_q [REG_NUM];

  // Writes to x0 are dropped here so the sequencer can report them normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && !is_x0(wa_i)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = is_x0(ra1_i) ? '0 : regs_q[ra1_i];
  assign rd2_o = is_x0(ra2_i) ? '0 : regs_q[ra2_i];

`ifdef ALU_SEQ_DBG_EN
  assign rd3_o = is_x0(ra3_i) ? '0 : regs_q[ra3_i];
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer in front of a registered ALU: read operands, wait the ALU latency,
// capture the result and write it back. Optional debug read port enabled by ALU_SEQ_DBG_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ALU_SEQ_DBG_EN
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
`endif
  alu_op_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LATENCY);

  seq_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [XLEN-1:0]   data_r1_q;
  logic [XLEN-1:0]   data_r2_q;
  logic [XLEN-1:0]   data_r2_d;
  logic              ctrl_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   result_q;
  logic              result_neg_q;
  logic              done_q;
  logic              ready_q;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic              wb_en;

  assign cnt_d     = cnt_q - CNT_W'(1);
  assign data_r2_d = bus.op_imm_sel ? bus.op_imm : rf_rd2;
  assign wb_en     = (state_q == WB);

  rv_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (bus.op_rs1),
    .ra2_i (bus.op_rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
`ifdef ALU_SEQ_DBG_EN
    .ra3_i (dbg_addr),
    .rd3_o (dbg_data),
`endif
    .we_i  (wb_en),
    .wa_i  (rd_q),
    .wd_i  (result_q)
  );

  // Ready stays low until the writeback edge so the next op always sees the committed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_r1_q    <= '0;
      data_r2_q    <= '0;
      ctrl_q       <= ALU_ADD;
      rd_q         <= '0;
      result_q     <= '0;
      result_neg_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid && ready_q) begin
            data_r1_q <= rf_rd1;
            data_r2_q <= data_r2_d;
            ctrl_q    <= bus.op_ctrl;
            rd_q      <= bus.op_rd;
            cnt_q     <= LAT_CNT;
            ready_q   <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            result_q     <= bus.ALUResult;
            result_neg_q <= bus.Negative;
            done_q       <= 1'b1;
            state_q      <= WB;
          end
        end
        WB: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready   = ready_q;
  assign bus.busy       = ~ready_q;
  assign bus.data_r1    = data_r1_q;
  assign bus.data_r2    = data_r2_q;
  assign bus.ALUControl = ctrl_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.result_neg = result_neg_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one DUT at ALU_LATENCY=1 and one at ALU_LATENCY=3.
// Debug-port checks are included when ALU_SEQ_DBG_EN is defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  alu_op_sequencer_if bus1 ();
  alu_op_sequencer_if bus3 ();

`ifdef ALU_SEQ_DBG_EN
  logic [4:0]  dbgAddr = 5'd0;
  logic [31:0] dbgData1;
  logic [31:0] dbgData3;
`endif

  alu_op_sequencer #(.ALU_LATENCY(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
`ifdef ALU_SEQ_DBG_EN
    .dbg_addr (dbgAddr),
    .dbg_data (dbgData1),
`endif
    .bus      (bus1)
  );

  alu_op_sequencer #(.ALU_LATENCY(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
`ifdef ALU_SEQ_DBG_EN
    .dbg_addr (dbgAddr),
    .dbg_data (dbgData3),
`endif
    .bus      (bus3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluOp(input logic [31:0] a, input logic [31:0] b, input logic c);
    return c ? (a - b) : (a + b);
  endfunction

  // The sequencer's operand registers are the ALU's input stage, so latency 1 is combinational here.
  assign bus1.ALUResult = aluOp(bus1.data_r1, bus1.data_r2, bus1.ALUControl);
  assign bus1.Negative  = bus1.ALUResult[31];

  logic [31:0] alu3S1;
  logic [31:0] alu3S2;
  always @(posedge clk) begin
    alu3S1 <= aluOp(bus3.data_r1, bus3.data_r2, bus3.ALUControl);
    alu3S2 <= alu3S1;
  end
  assign bus3.ALUResult = alu3S2;
  assign bus3.Negative  = alu3S2[31];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic immSel, input logic [31:0] imm, input logic ctrl);
    bus1.op_rs1 = rs1;  bus3.op_rs1 = rs1;
    bus1.op_rs2 = rs2;  bus3.op_rs2 = rs2;
    bus1.op_rd  = rd;   bus3.op_rd  = rd;
    bus1.op_imm_sel = immSel;  bus3.op_imm_sel = immSel;
    bus1.op_imm  = imm;  bus3.op_imm  = imm;
    bus1.op_ctrl = ctrl; bus3.op_ctrl = ctrl;
  endtask

  task automatic setValid(input int lat, input logic v);
    if (lat == 1) bus1.op_valid = v;
    else          bus3.op_valid = v;
  endtask

  task automatic sample(input int lat, output logic rdy, output logic bsy, output logic dn,
                        output logic ctl, output logic neg, output logic [31:0] r1,
                        output logic [31:0] r2, output logic [31:0] res);
    if (lat == 1) begin
      rdy = bus1.op_ready; bsy = bus1.busy; dn = bus1.done; ctl = bus1.ALUControl;
      neg = bus1.result_neg; r1 = bus1.data_r1; r2 = bus1.data_r2; res = bus1.result;
    end else begin
      rdy = bus3.op_ready; bsy = bus3.busy; dn = bus3.done; ctl = bus3.ALUControl;
      neg = bus3.result_neg; r1 = bus3.data_r1; r2 = bus3.data_r2; res = bus3.result;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after writeback.
  task automatic runOp(input int lat, input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic immSel, input logic [31:0] imm,
                       input logic ctrl, input logic [31:0] expR1, input logic [31:0] expR2,
                       input logic [31:0] expRes, input logic expNeg);
    logic rdy, bsy, dn, ctl, neg;
    logic [31:0] r1, r2, res;
    applyStimulus(rs1, rs2, rd, immSel, imm, ctrl);
    sample(lat, rdy, bsy, dn, ctl, neg, r1, r2, res);
    checkOutput($sformatf("%s_ready_in", tag), 32'(rdy), 32'd1);
    setValid(lat, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setValid(lat, 1'b0);
    sample(lat, rdy, bsy, dn, ctl, neg, r1, r2, res);
    checkOutput($sformatf("%s_busy", tag), 32'(bsy), 32'd1);
    checkOutput($sformatf("%s_ready_lo", tag), 32'(rdy), 32'd0);
    checkOutput($sformatf("%s_data_r1", tag), r1, expR1);
    checkOutput($sformatf("%s_data_r2", tag), r2, expR2);
    checkOutput($sformatf("%s_ctrl", tag), 32'(ctl), 32'(ctrl));
    checkOutput($sformatf("%s_done_early", tag), 32'(dn), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      sample(lat, rdy, bsy, dn, ctl, neg, r1, r2, res);
      checkOutput($sformatf("%s_done_c%0d", tag, k), 32'(dn), 32'(k == lat));
      if (k == lat) begin
        checkOutput($sformatf("%s_result", tag), res, expRes);
        checkOutput($sformatf("%s_neg", tag), 32'(neg), 32'(expNeg));
        checkOutput($sformatf("%s_ready_wb", tag), 32'(rdy), 32'd0);
      end
    end
    @(negedge clk);
    sample(lat, rdy, bsy, dn, ctl, neg, r1, r2, res);
    checkOutput($sformatf("%s_done_off", tag), 32'(dn), 32'd0);
    checkOutput($sformatf("%s_ready_back", tag), 32'(rdy), 32'd1);
  endtask

  initial begin
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    bus1.op_valid = 1'b0;
    bus3.op_valid = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(bus1.op_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus1.busy), 32'd0);
    checkOutput("rst_done", 32'(bus1.done), 32'd0);
    checkOutput("rst_data_r1", bus1.data_r1, 32'd0);
    checkOutput("rst_data_r2", bus1.data_r2, 32'd0);
    checkOutput("rst_result", bus1.result, 32'd0);
    checkOutput("rst_result_neg", 32'(bus1.result_neg), 32'd0);
    checkOutput("rst_ctrl", 32'(bus1.ALUControl), 32'd0);
    checkOutput("rst_ready3", 32'(bus3.op_ready), 32'd1);
`ifdef ALU_SEQ_DBG_EN
    dbgAddr = 5'd7;
    #1;
    checkOutput("rst_dbg7", dbgData1, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    runOp(1, "imm14", 5'd0, 5'd0, 5'd1, 1'b1, 32'd14, 1'b0, 32'd0, 32'd14, 32'd14, 1'b0);
    runOp(1, "imm15", 5'd0, 5'd0, 5'd2, 1'b1, 32'd15, 1'b0, 32'd0, 32'd15, 32'd15, 1'b0);
`ifdef ALU_SEQ_DBG_EN
    dbgAddr = 5'd1;
    #1;
    checkOutput("dbg_x1", dbgData1, 32'h0000_000E);
    dbgAddr = 5'd0;
    #1;
    checkOutput("dbg_x0", dbgData1, 32'd0);
`endif

    runOp(1, "sub", 5'd1, 5'd2, 5'd3, 1'b0, 32'hDEAD_BEEF, 1'b1,
          32'd14, 32'd15, 32'hFFFF_FFFF, 1'b1);
    runOp(1, "add", 5'd1, 5'd2, 5'd4, 1'b0, 32'd0, 1'b0, 32'd14, 32'd15, 32'd29, 1'b0);
    runOp(1, "rd_x3", 5'd3, 5'd4, 5'd5, 1'b0, 32'd0, 1'b1,
          32'hFFFF_FFFF, 32'd29, 32'hFFFF_FFE2, 1'b1);
    runOp(1, "imm_msb", 5'd4, 5'd0, 5'd6, 1'b1, 32'h8000_0000, 1'b0,
          32'd29, 32'h8000_0000, 32'h8000_001D, 1'b1);

    runOp(1, "x0_wr", 5'd1, 5'd2, 5'd0, 1'b0, 32'd0, 1'b0, 32'd14, 32'd15, 32'd29, 1'b0);
    runOp(1, "x0_rd", 5'd0, 5'd0, 5'd6, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    // op_valid held high: accepts land every third cycle, nothing queued while busy.
    applyStimulus(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b0);
    bus1.op_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("stress_ready%0d", i), 32'(bus1.op_ready), 32'((i % 3) == 0));
      checkOutput($sformatf("stress_done%0d", i), 32'(bus1.done), 32'((i % 3) == 2));
      if ((i % 3) == 2) checkOutput($sformatf("stress_result%0d", i), bus1.result, 32'd29);
      if (i == 11) bus1.op_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("stress_idle", 32'(bus1.op_ready), 32'd1);

    applyStimulus(5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b1);
    bus1.op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.op_valid = 1'b0;
    checkOutput("abort_in_wait", 32'(bus1.op_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(bus1.op_ready), 32'd1);
    checkOutput("abort_busy", 32'(bus1.busy), 32'd0);
    checkOutput("abort_done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    checkOutput("abort_done_hold", 32'(bus1.done), 32'd0);
    checkOutput("abort_result", bus1.result, 32'd0);
`ifdef ALU_SEQ_DBG_EN
    dbgAddr = 5'd3;
    #1;
    checkOutput("abort_dbg_x3", dbgData1, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_done_after", 32'(bus1.done), 32'd0);
    checkOutput("abort_ready_after", 32'(bus1.op_ready), 32'd1);
    runOp(1, "after_rst", 5'd1, 5'd2, 5'd8, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    runOp(3, "lat_ld", 5'd0, 5'd0, 5'd1, 1'b1, 32'd100, 1'b0, 32'd0, 32'd100, 32'd100, 1'b0);
    runOp(3, "lat_sub", 5'd1, 5'd0, 5'd2, 1'b1, 32'd58, 1'b1, 32'd100, 32'd58, 32'd42, 1'b0);
    runOp(3, "lat_neg", 5'd2, 5'd1, 5'd3, 1'b0, 32'd0, 1'b1,
          32'd42, 32'd100, 32'hFFFF_FFC6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
